// File: rtl/mul_shift_add_seq.sv
// Sequential radix-2 shift-and-add multiplier with start/busy/done handshake,
// optional early termination on an exhausted multiplier, and signed/unsigned operands.
module mul_shift_add_seq #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [SW-1:0]    step_q, step_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    addend;
  logic [WIDTH-1:0] mb_shift;

  always_comb begin
    // Magnitudes: -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    abs_a    = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
    abs_b    = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
    addend   = {{WIDTH{1'b0}}, ma_q} << step_q;
    mb_shift = mb_q >> 1;

    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    step_d    = step_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ma_d    = abs_a;
          mb_d    = abs_b;
          neg_d   = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          acc_d   = '0;
          step_d  = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (mb_q[0]) begin
            acc_d = acc_q + addend;
          end
          mb_d   = mb_shift;
          step_d = step_q + 1'b1;
          if ((step_q == LAST_STEP) || (EARLY_TERM && (mb_shift == '0))) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          product_d = neg_q ? -acc_q : acc_q;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == S_CALC) || (state_q == S_FIX);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul_shift_add_seq.sv
// Randomised bench for mul_shift_add_seq: instance 0 uses early termination,
// instance 1 fixed-length iteration; results and latencies come from an arithmetic model.
module tb_mul_shift_add_seq;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start;
  logic [1:0]  sm;
  logic [1:0]  abort;
  logic [15:0] a [2];
  logic [15:0] b [2];
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [31:0] prod [2];

  int total = 0;
  int bad   = 0;

  mul_shift_add_seq #(.WIDTH(16), .EARLY_TERM(1'b1)) u_et (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .signed_mode(sm[0]),
    .a_in(a[0]), .b_in(b[0]), .abort(abort[0]),
    .busy(busy[0]), .done(done[0]), .product(prod[0])
  );

  mul_shift_add_seq #(.WIDTH(16), .EARLY_TERM(1'b0)) u_fx (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .signed_mode(sm[1]),
    .a_in(a[1]), .b_in(b[1]), .abort(abort[1]),
    .busy(busy[1]), .done(done[1]), .product(prod[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true product of the operands as integers.
  function automatic logic [31:0] model_prod(input bit smode, input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] sx, sy, sr;
    if (smode) begin
      sx = $signed(x);
      sy = $signed(y);
      sr = sx * sy;
      return sr;
    end
    return {16'd0, x} * {16'd0, y};
  endfunction

  // Reference: number of iteration edges = bit length of |multiplier| (at least 1), or 16 when fixed.
  function automatic int model_n(input int inst, input bit smode, input logic [15:0] y);
    int v;
    int n;
    if (inst == 1) return 16;
    v = smode ? int'($signed(y)) : int'(y);
    if (v < 0) v = -v;
    n = 1;
    while ((v >> n) != 0) n++;
    return n;
  endfunction

  // Issues one operation at posedge+1 and returns the edge count to done plus handshake health.
  task automatic run_op(input int inst, input bit smode, input logic [15:0] x, input logic [15:0] y,
                        output logic [31:0] p, output int lat, output bit busy_ok, output bit pulse_ok);
    start[inst] = 1'b1;
    sm[inst]    = smode;
    a[inst]     = x;
    b[inst]     = y;
    @(posedge clk); #1;
    start[inst] = 1'b0;
    busy_ok  = (busy[inst] === 1'b1);
    pulse_ok = 1'b1;
    lat = -1;
    p   = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done[inst] === 1'b1) begin
        lat = k;
        p   = prod[inst];
        if (busy[inst] !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy[inst] !== 1'b1) busy_ok = 1'b0;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      pulse_ok = (done[inst] === 1'b0);
    end
    $display("op inst=%0d s=%0d a=%h b=%h -> p=%h lat=%0d", inst, smode, x, y, p, lat);
  endtask

  task automatic check_op(input string name, input int inst, input bit smode,
                          input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    int lat;
    bit bok, pok;
    run_op(inst, smode, x, y, p, lat, bok, pok);
    total++;
    if (p !== model_prod(smode, x, y)) begin
      bad++;
      $display("FAIL %s product a=%h b=%h got=%h want=%h", name, x, y, p, model_prod(smode, x, y));
    end
    total++;
    if (lat !== model_n(inst, smode, y) + 1) begin
      bad++;
      $display("FAIL %s latency a=%h b=%h got=%0d want=%0d", name, x, y, lat, model_n(inst, smode, y) + 1);
    end
    total++;
    if (!bok || !pok) begin
      bad++;
      $display("FAIL %s handshake busy_ok=%0d pulse_ok=%0d want 1/1", name, bok, pok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0 || prod[i] !== 32'd0) begin
        bad++;
        $display("FAIL reset inst=%0d busy=%b done=%b prod=%h want 0/0/0", i, busy[i], done[i], prod[i]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 2'b00 || done !== 2'b00) begin
      bad++;
      $display("FAIL reset_release busy=%b done=%b want 00/00", busy, done);
    end
    $display("reset checked");
  endtask

  task automatic test_unsigned();
    check_op("unsigned_3x5", 0, 1'b0, 16'd3, 16'd5);
    for (int i = 0; i < 15; i++)
      check_op("unsigned_rand", 0, 1'b0, 16'($urandom), 16'($urandom_range(0, 65535) >> $urandom_range(0, 15)));
  endtask

  task automatic test_signed();
    check_op("signed_m3x7", 0, 1'b1, 16'hFFFD, 16'd7);
    check_op("signed_m4xm6", 0, 1'b1, 16'hFFFC, 16'hFFFA);
    for (int i = 0; i < 15; i++)
      check_op("signed_rand", 0, 1'b1, 16'($urandom), 16'($urandom));
  endtask

  task automatic test_corners();
    check_op("corner_min_sq", 0, 1'b1, 16'h8000, 16'h8000);
    check_op("corner_max_sq", 0, 1'b0, 16'hFFFF, 16'hFFFF);
    check_op("corner_b0", 0, 1'b0, 16'h1234, 16'h0000);
    check_op("corner_b0_signed", 0, 1'b1, 16'h8001, 16'h0000);
    check_op("corner_b1", 0, 1'b1, 16'hFFFF, 16'h0001);
  endtask

  task automatic test_fixed();
    check_op("fixed_b0", 1, 1'b0, 16'h00AB, 16'h0000);
    check_op("fixed_min_sq", 1, 1'b1, 16'h8000, 16'h8000);
    for (int i = 0; i < 10; i++)
      check_op("fixed_rand", 1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
  endtask

  task automatic test_busy_start();
    int lat;
    logic [31:0] p;
    start[0] = 1'b1; sm[0] = 1'b0; a[0] = 16'd3; b[0] = 16'h00FF;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    start[0] = 1'b1; a[0] = 16'h1234; b[0] = 16'h0011;
    @(posedge clk); #1;
    start[0] = 1'b0;
    lat = -1;
    p = 'x;
    for (int k = 3; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) begin
        lat = k;
        p = prod[0];
        break;
      end
    end
    $display("busy_start -> p=%h lat=%0d", p, lat);
    total++;
    if (p !== 32'h0000_02FD || lat !== 9) begin
      bad++;
      $display("FAIL busy_start got p=%h lat=%0d want p=000002fd lat=9", p, lat);
    end
    total++;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        bad++;
        $display("FAIL busy_start_queued cycle=%0d done=%b busy=%b want 0/0", k, done[0], busy[0]);
        break;
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] p_prev;
    logic [31:0] p;
    int lat;
    bit bok, pok;
    logic [15:0] x;
    x = 16'($urandom) | 16'h0101;
    run_op(0, 1'b0, x, 16'h0033, p_prev, lat, bok, pok);
    start[0] = 1'b1; sm[0] = 1'b0; a[0] = 16'h7777; b[0] = 16'hFFFF;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy got=%b want=0", busy[0]);
    end
    total++;
    for (int k = 0; k < 20; k++) begin
      if (done[0] !== 1'b0) begin
        bad++;
        $display("FAIL abort_done cycle=%0d got=%b want=0", k, done[0]);
        break;
      end
      @(posedge clk); #1;
    end
    total++;
    if (prod[0] !== model_prod(1'b0, x, 16'h0033)) begin
      bad++;
      $display("FAIL abort_product got=%h want=%h", prod[0], model_prod(1'b0, x, 16'h0033));
    end
    $display("abort -> product held %h", prod[0]);
    // abort together with start in IDLE: start wins
    abort[0] = 1'b1;
    start[0] = 1'b1; sm[0] = 1'b1; a[0] = 16'hFFF0; b[0] = 16'h0009;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    start[0] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (prod[0] !== 32'hFFFF_FF70 || lat !== 5) begin
      bad++;
      $display("FAIL abort_start_same got p=%h lat=%0d want p=ffffff70 lat=5", prod[0], lat);
    end
    $display("abort+start -> p=%h lat=%0d", prod[0], lat);
  endtask

  task automatic test_reset_mid();
    start[0] = 1'b1; sm[0] = 1'b0; a[0] = 16'h4321; b[0] = 16'hF00F;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || prod[0] !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid busy=%b done=%b prod=%h want 0/0/0", busy[0], done[0], prod[0]);
    end
    $display("reset mid-operation -> busy=%b prod=%h", busy[0], prod[0]);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (done[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_done got=%b want=0", done[0]);
    end
    check_op("after_reset", 0, 1'b1, 16'hFF9C, 16'h0064);
  endtask

  task automatic test_back_to_back();
    logic [15:0] x1, y1, x2, y2;
    int lat;
    x1 = 16'($urandom); y1 = 16'($urandom_range(1, 255));
    x2 = 16'($urandom); y2 = 16'($urandom);
    start[0] = 1'b1; sm[0] = 1'b0; a[0] = x1; b[0] = y1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat !== model_n(0, 1'b0, y1) + 1 || prod[0] !== model_prod(1'b0, x1, y1)) begin
      bad++;
      $display("FAIL b2b_first got p=%h lat=%0d want p=%h lat=%0d",
               prod[0], lat, model_prod(1'b0, x1, y1), model_n(0, 1'b0, y1) + 1);
    end
    start[0] = 1'b1; sm[0] = 1'b1; a[0] = x2; b[0] = y2;
    @(posedge clk); #1;
    start[0] = 1'b0;
    total++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept done=%b busy=%b want 0/1", done[0], busy[0]);
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat !== model_n(0, 1'b1, y2) + 1 || prod[0] !== model_prod(1'b1, x2, y2)) begin
      bad++;
      $display("FAIL b2b_second got p=%h lat=%0d want p=%h lat=%0d",
               prod[0], lat, model_prod(1'b1, x2, y2), model_n(0, 1'b1, y2) + 1);
    end
    $display("back-to-back -> p=%h lat=%0d", prod[0], lat);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    sm    = '0;
    abort = '0;
    a[0] = '0; a[1] = '0;
    b[0] = '0; b[1] = '0;
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_corners();
    test_fixed();
    test_busy_start();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
